bcd_score_counter: RTL and testbench
====================================

// Module: bcd_score_counter
// PURPOSE
//   Parametrised multi-digit BCD score counter for the game datapath; drives the 7-seg display path directly.
//   Counts synchronised, edge-detected increment events, each adding a 0..9 step, with saturation and a game clear.
//   Optional high-score register with a one-cycle new-record pulse.
// PARAMETERS
//   DIGITS     4  number of BCD digits; score width = 4*DIGITS; legal range 1..8
//   SYNC_STAGES 2 synchroniser depth for inc and clear inputs; legal range 2..3
// PORTS
//   clk         in   1         system clock, all logic on rising edge
//   reset       in   1         asynchronous, active-high; clears every register
//   inc         in   1         increment request (async level); one event per rising edge
//   step        in   4         BCD amount added per event; sampled on the event cycle; values >9 treated as 9
//   clear       in   1         game restart (async level), synchronised, level-sensitive
//   score       out  4*DIGITS  current score, packed BCD, digit 0 = bits [3:0]
//   saturated   out  1         high once score has clamped at all-9s; cleared by clear/reset
//   hiscore     out  4*DIGITS  best score since reset (HISCORE_EN only, else tied 0)
//   new_record  out  1         one-cycle pulse when hiscore updates (HISCORE_EN only, else 0)
// BEHAVIOUR
//   - Reset (async): score=0, saturated=0, hiscore=0, new_record=0, all synchroniser/edge flops=0.
//   - inc passes SYNC_STAGES flops then an edge flop; event = sync_out & ~edge_q.
//     With SYNC_STAGES=2: inc first sampled high at edge N -> score updated at edge N+2. Holding inc high = one event.
//   - Event add: ripple BCD add of clamp(step) into digit 0, carry through all digits in the same cycle.
//     Digit rule: s=d+c_in(+step on digit0); if s>9 then d=s-10, carry=1.
//   - Saturation: carry out of the top digit -> score forced to all 9s, saturated=1. Further events ignored.
//   - clear (synchronised): while high, score=0 and saturated=0 each cycle; clear wins over a simultaneous event.
//     An event whose edge falls while clear is high is discarded, not deferred.
//   - step=0 event: no change, no flag activity.
//   - Reset mid-count or mid-pulse: all state returns to reset values immediately; no pending event survives.
//   - Outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//   HISCORE_EN defined: hiscore register, compared against score each cycle (BCD compare = unsigned compare).
//     If score > hiscore at edge N, hiscore<=score and new_record=1 for cycle N+1 only. clear does not touch hiscore.
//   HISCORE_EN undefined: no compare logic or register; hiscore=0, new_record=0 constants.
// STRUCTURE
//   Package score_pkg: BCD_W=4, BCD_MAX=4'd9, function bcd_clamp(step), max DIGITS constant.
//   Sub-module bcd_digit: one digit register + adder (d, add_in, c_in -> d_next, c_out);
//     instantiated DIGITS times in a generate loop; saturation and clear handled in the top.
//   Top holds synchronisers, edge detector, saturation/clear control, optional hiscore.
// TESTING (DIGITS=4, SYNC_STAGES=2)
//   1 reset, inc pulse with step=1 -> score 16'h0001 two edges after first sample; held inc gives no second count.
//   2 score 16'h0009, event step=1 -> 16'h0010; score 16'h0999, step=5 -> 16'h1004 (multi-digit carry).
//   3 score 16'h9995, event step=7 -> 16'h9999, saturated=1; next event step=1 -> unchanged.
//   4 clear and inc edge in same synchronised cycle -> score 0, saturated 0, event lost; step=4'hF -> adds 9.
//   5 HISCORE_EN: score 16'h0012, hiscore 16'h0010 -> hiscore 16'h0012, new_record one cycle; clear keeps hiscore.
//   6 async reset asserted between clock edges mid-count -> all outputs 0 before next edge; build without HISCORE_EN -> hiscore=0.

Source files
------------

// File: rtl/bcd_score_counter_pkg.sv
// Shared BCD constants and step clamp for the score counter slice.
// Included by the digit cell, the top and the port interface.
package score_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam int MAX_DIGITS = 8;

  // Steps above 9 are not legal BCD; treat them as the largest digit.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] step);
    return (step > BCD_MAX) ? BCD_MAX : step;
  endfunction

endpackage

// File: rtl/bcd_score_counter_if.sv
// Score counter port bundle: async request/clear/step towards the counter, registered score back.
// master = game logic / bench side, slave = bcd_score_counter.
interface bcd_score_counter_if import score_pkg::*; #(parameter int DIGITS = 4);

  logic                      inc;
  logic [BCD_W-1:0]          step;
  logic                      clear;
  logic [BCD_W*DIGITS-1:0]   score;
  logic                      saturated;
  logic [BCD_W*DIGITS-1:0]   hiscore;
  logic                      new_record;

  modport master (
    output inc, step, clear,
    input  score, saturated, hiscore, new_record
  );

  modport slave (
    input  inc, step, clear,
    output score, saturated, hiscore, new_record
  );

endinterface

// File: rtl/bcd_score_counter_digit.sv
// One BCD digit: register plus decimal adder (d + add_in + c_in -> d_next, c_out).
// Latency 1 cycle on load; clear and force-to-9 are steered by the parent.
module bcd_digit import score_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             force_max,
  input  logic [BCD_W-1:0] add_in,
  input  logic             c_in,
  output logic [BCD_W-1:0] d,
  output logic             c_out
);

  logic [BCD_W:0]   sum;
  logic [BCD_W-1:0] d_next;

  always_comb begin
    sum = {1'b0, d} + {1'b0, add_in} + {{BCD_W{1'b0}}, c_in};
    if (sum > {1'b0, BCD_MAX}) begin
      d_next = BCD_W'(sum - (BCD_W+1)'(10));
      c_out  = 1'b1;
    end else begin
      d_next = sum[BCD_W-1:0];
      c_out  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d <= '0;
    end else if (clr) begin
      d <= '0;
    end else if (force_max) begin
      d <= BCD_MAX;
    end else if (load) begin
      d <= d_next;
    end
  end

endmodule

// File: rtl/bcd_score_counter.sv
// Multi-digit saturating BCD score counter with synchronised, edge-detected increments and level clear.
// Latency: inc sampled at edge N -> score at edge N+SYNC_STAGES; no backpressure. Optional HISCORE_EN adds high-score tracking.
module bcd_score_counter import score_pkg::*; #(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                reset,
  bcd_score_counter_if.slave bus
);

  localparam int W = BCD_W * DIGITS;

  logic [SYNC_STAGES-1:0] inc_sync;
  logic [SYNC_STAGES-1:0] clr_sync;
  logic                   edge_q;
  logic                   inc_event;
  logic                   clear_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_sync <= '0;
      clr_sync <= '0;
      edge_q   <= 1'b0;
    end else begin
      inc_sync <= {inc_sync[SYNC_STAGES-2:0], bus.inc};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], bus.clear};
      edge_q   <= inc_sync[SYNC_STAGES-1];
    end
  end

  assign inc_event = inc_sync[SYNC_STAGES-1] & ~edge_q;
  assign clear_s   = clr_sync[SYNC_STAGES-1];

  logic [W-1:0]     score_q;
  logic [DIGITS:0]  carry;
  logic [BCD_W-1:0] step_c;
  logic             sat_q;
  logic             accept;
  logic             load;
  logic             force_max;

  assign step_c   = bcd_clamp(bus.step);
  assign carry[0] = 1'b0;

  // Clear beats a coincident event, and a saturated score ignores further events.
  assign accept    = inc_event & ~sat_q & ~clear_s;
  assign load      = accept & ~carry[DIGITS];
  assign force_max = accept &  carry[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .clr       (clear_s),
      .load      (load),
      .force_max (force_max),
      .add_in    ((i == 0) ? step_c : {BCD_W{1'b0}}),
      .c_in      (carry[i]),
      .d         (score_q[i*BCD_W +: BCD_W]),
      .c_out     (carry[i+1])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else if (clear_s) begin
      sat_q <= 1'b0;
    end else if (force_max) begin
      sat_q <= 1'b1;
    end
  end

  assign bus.score     = score_q;
  assign bus.saturated = sat_q;

`ifdef HISCORE_EN
  logic [W-1:0] hi_q;
  logic         new_rec_q;

  // Packed BCD orders the same as its unsigned binary reading.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= '0;
      new_rec_q <= 1'b0;
    end else if (score_q > hi_q) begin
      hi_q      <= score_q;
      new_rec_q <= 1'b1;
    end else begin
      new_rec_q <= 1'b0;
    end
  end

  assign bus.hiscore    = hi_q;
  assign bus.new_record = new_rec_q;
`else
  assign bus.hiscore    = '0;
  assign bus.new_record = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_score_counter.sv
// Bench for bcd_score_counter: integer score model plus directed literal checks and random traffic.
`timescale 1ns/1ps
module tb_bcd_score_counter;
  import score_pkg::*;

  localparam int DIGITS      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int W           = 4 * DIGITS;
  localparam int unsigned MAXV = 10**DIGITS - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int checks   = 0;
  int failures = 0;

  bcd_score_counter_if #(.DIGITS(DIGITS)) bus();

  bcd_score_counter #(.DIGITS(DIGITS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference: score kept as a plain decimal integer; input samples kept per edge.
  int unsigned m_score = 0;
  int unsigned m_hi    = 0;
  bit          m_sat   = 1'b0;
  bit          m_nr    = 1'b0;
  bit          inc_h[5];
  bit          clr_h[5];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_score = 0;
      m_hi    = 0;
      m_sat   = 1'b0;
      m_nr    = 1'b0;
      for (int i = 0; i < 5; i++) begin
        inc_h[i] = 1'b0;
        clr_h[i] = 1'b0;
      end
    end else begin
      bit          ev;
      bit          cl;
      int unsigned sum;
      ev = inc_h[SYNC_STAGES-1] && !inc_h[SYNC_STAGES];
      cl = clr_h[SYNC_STAGES-1];
`ifdef HISCORE_EN
      m_nr = (m_score > m_hi);
      if (m_nr) m_hi = m_score;
`endif
      if (cl) begin
        m_score = 0;
        m_sat   = 1'b0;
      end else if (ev && !m_sat) begin
        sum = m_score + ((bus.step > 4'd9) ? 9 : int'(bus.step));
        if (sum > MAXV) begin
          m_score = MAXV;
          m_sat   = 1'b1;
        end else begin
          m_score = sum;
        end
      end
      for (int i = 4; i > 0; i--) begin
        inc_h[i] = inc_h[i-1];
        clr_h[i] = clr_h[i-1];
      end
      inc_h[0] = bus.inc;
      clr_h[0] = bus.clear;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("score",      bus.score,      to_bcd(m_score));
      chk("saturated",  bus.saturated,  m_sat);
      chk("hiscore",    bus.hiscore,    to_bcd(m_hi));
      chk("new_record", bus.new_record, m_nr);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // One-cycle inc pulse; step held until the event edge has passed.
  task automatic pulse(input logic [3:0] s);
    bus.step = s;
    bus.inc  = 1'b1;
    cyc(1);
    bus.inc  = 1'b0;
    cyc(2);
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bus.inc   = 1'b0;
    bus.step  = 4'd0;
    bus.clear = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    chk("rst_score", bus.score, 32'h0);
    chk("rst_sat",   bus.saturated, 32'h0);
    chk("rst_hi",    bus.hiscore, 32'h0);
    chk("rst_nr",    bus.new_record, 32'h0);

    // Latency and held inc.
    bus.step = 4'd1;
    bus.inc  = 1'b1;
    cyc(2);
    chk("t1_before", bus.score, 32'h0000);
    cyc(1);
    chk("t1_first", bus.score, 32'h0001);
    cyc(5);
    chk("t1_held", bus.score, 32'h0001);
    bus.inc = 1'b0;
    cyc(2);

    // Carries.
    repeat (8) pulse(4'd1);
    chk("t2_0009", bus.score, 32'h0009);
    pulse(4'd1);
    chk("t2_0010", bus.score, 32'h0010);
    repeat (109) pulse(4'd9);
    repeat (8) pulse(4'd1);
    chk("t2_0999", bus.score, 32'h0999);
    pulse(4'd5);
    chk("t2_1004", bus.score, 32'h1004);

    // Saturation.
    repeat (999) pulse(4'd9);
    chk("t3_9995", bus.score, 32'h9995);
    chk("t3_nosat", bus.saturated, 32'h0);
    pulse(4'd7);
    chk("t3_9999", bus.score, 32'h9999);
    chk("t3_sat", bus.saturated, 32'h1);
    pulse(4'd1);
    chk("t3_hold", bus.score, 32'h9999);
    chk("t3_sathold", bus.saturated, 32'h1);

    // Clear coinciding with an inc edge, then oversized step.
    bus.step  = 4'd1;
    bus.clear = 1'b1;
    bus.inc   = 1'b1;
    cyc(4);
    chk("t4_clr_score", bus.score, 32'h0);
    chk("t4_clr_sat", bus.saturated, 32'h0);
    bus.clear = 1'b0;
    cyc(4);
    chk("t4_lost", bus.score, 32'h0);
    bus.inc = 1'b0;
    cyc(2);
    pulse(4'hF);
    chk("t4_clamp", bus.score, 32'h0009);

    // Async reset between edges with an event pending.
    bus.step = 4'd3;
    bus.inc  = 1'b1;
    cyc(2);
    reset   = 1'b1;
    bus.inc = 1'b0;
    #1;
    chk("t6_score", bus.score, 32'h0);
    chk("t6_sat", bus.saturated, 32'h0);
    chk("t6_hi", bus.hiscore, 32'h0);
    chk("t6_nr", bus.new_record, 32'h0);
    cyc(1);
    reset = 1'b0;
    cyc(3);
    chk("t6_nopend", bus.score, 32'h0);

    // High score.
    pulse(4'd9);
    pulse(4'd1);
    cyc(2);
    pulse(4'd2);
    chk("t5_score", bus.score, 32'h0012);
`ifdef HISCORE_EN
    chk("t5_hi_old", bus.hiscore, 32'h0010);
    chk("t5_nr_pre", bus.new_record, 32'h0);
    cyc(1);
    chk("t5_hi_new", bus.hiscore, 32'h0012);
    chk("t5_nr", bus.new_record, 32'h1);
    cyc(1);
    chk("t5_nr_end", bus.new_record, 32'h0);
    bus.clear = 1'b1;
    cyc(4);
    bus.clear = 1'b0;
    cyc(1);
    chk("t5_clr_score", bus.score, 32'h0);
    chk("t5_clr_hi", bus.hiscore, 32'h0012);
`else
    cyc(2);
    chk("t5_hi_tied", bus.hiscore, 32'h0);
    chk("t5_nr_tied", bus.new_record, 32'h0);
`endif

    // Random traffic with clears and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      bus.inc   = 1'($urandom_range(0, 1));
      bus.step  = 4'($urandom_range(0, 15));
      bus.clear = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 600) == 0) begin
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
      end
      cyc(1);
    end
    bus.clear = 1'b0;

    // Long run without clears so the score reaches saturation.
    for (int n = 0; n < 3000; n++) begin
      bus.inc  = ~bus.inc;
      bus.step = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd9;
      cyc(1);
    end
    chk("rand_sat", bus.saturated, 32'h1);
    bus.clear = 1'b1;
    cyc(4);
    bus.clear = 1'b0;
    cyc(2);
    chk("rand_clr", bus.score, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
